// File: rtl/crossbar_in_arbiter.sv
// crossbar_in_arbiter: request-side crossbar stage in front of banked SRAMs.
// Per bank, picks at most one requesting PE per cycle (bank = low address
// bits), grants it combinationally and registers a single SRAM command for
// that bank. o_peID carries a one-hot reader bitmap so the return path can
// steer read data back to the right PE.
// Build option: define CROSSBAR_IN_RR_EN for per-bank round-robin
// arbitration; otherwise the lowest-numbered PE always wins.
module crossbar_in_arbiter #(
    parameter int NUM_PE     = 4,
    parameter int NUM_BANK   = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic [NUM_PE-1:0]                                 i_req,
    input  logic [NUM_PE-1:0]                                 i_wren,
    input  logic [NUM_PE*ADDR_WIDTH-1:0]                      i_addr,
    input  logic [NUM_PE*DATA_WIDTH-1:0]                      i_wdata,
    input  logic [NUM_PE*(DATA_WIDTH/8)-1:0]                  i_wstrb,
    output logic [NUM_PE-1:0]                                 o_gnt,
    output logic [NUM_BANK-1:0]                               o_ram_en,
    output logic [NUM_BANK-1:0]                               o_ram_wren,
    output logic [NUM_BANK*(ADDR_WIDTH-$clog2(NUM_BANK))-1:0] o_ram_addr,
    output logic [NUM_BANK*DATA_WIDTH-1:0]                    o_ram_wdata,
    output logic [NUM_BANK*(DATA_WIDTH/8)-1:0]                o_ram_wstrb,
    output logic [NUM_BANK*NUM_PE-1:0]                        o_peID,
    output logic [15:0]                                       o_conflict_cnt
);

    localparam int BANK_W  = $clog2(NUM_BANK);
    localparam int PE_W    = $clog2(NUM_PE);
    localparam int LADDR_W = ADDR_WIDTH - BANK_W;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int DENY_W  = $clog2(NUM_PE + 1);

    // One-hot winner per bank, gathered into the PE-side grant vector
    logic [NUM_BANK-1:0][NUM_PE-1:0] win_oh;
    logic [NUM_PE-1:0]               gnt_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANK; gi++) begin : bank_g
            logic [NUM_PE-1:0]  cand;
            logic [PE_W-1:0]    start_ptr;
            logic [PE_W-1:0]    sel_idx;
            logic               sel_vld;
            logic               ram_en_q;
            logic               ram_wren_q;
            logic [LADDR_W-1:0] ram_addr_q;
            logic [DATA_WIDTH-1:0] ram_wdata_q;
            logic [STRB_W-1:0]  ram_wstrb_q;
            logic [NUM_PE-1:0]  peid_q;

`ifdef CROSSBAR_IN_RR_EN
            logic [PE_W-1:0]    rr_ptr_q;
            logic [PE_W-1:0]    rr_ptr_d;

            // Advance past the winner so it becomes lowest priority next time
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (sel_vld) begin
                    rr_ptr_d = sel_idx + PE_W'(1);
                end
            end

            // Round-robin pointer register
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end

            assign start_ptr = rr_ptr_q;
`else
            assign start_ptr = '0;
`endif

            // Which PEs are asking for this bank
            always_comb begin
                cand = '0;
                for (int p = 0; p < NUM_PE; p++) begin
                    cand[p] = i_req[p] &&
                              (i_addr[p*ADDR_WIDTH +: BANK_W] == BANK_W'(gi));
                end
            end

            // Scan upward from the start pointer, wrapping mod NUM_PE
            always_comb begin
                logic [PE_W-1:0] scan_idx;
                scan_idx = '0;
                sel_vld  = 1'b0;
                sel_idx  = '0;
                for (int k = 0; k < NUM_PE; k++) begin
                    scan_idx = start_ptr + PE_W'(k);
                    if (!sel_vld && cand[scan_idx]) begin
                        sel_vld = 1'b1;
                        sel_idx = scan_idx;
                    end
                end
            end

            assign win_oh[gi] = sel_vld ? (NUM_PE'(1) << sel_idx) : '0;

            // Register the winner's command; addr/data/strobe hold when idle
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    ram_en_q    <= 1'b0;
                    ram_wren_q  <= 1'b0;
                    ram_addr_q  <= '0;
                    ram_wdata_q <= '0;
                    ram_wstrb_q <= '0;
                    peid_q      <= '0;
                end else begin
                    ram_en_q   <= sel_vld;
                    ram_wren_q <= sel_vld && i_wren[sel_idx];
                    peid_q     <= (sel_vld && !i_wren[sel_idx]) ? win_oh[gi] : '0;
                    if (sel_vld) begin
                        ram_addr_q  <= i_addr[sel_idx*ADDR_WIDTH + BANK_W +: LADDR_W];
                        ram_wdata_q <= i_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        ram_wstrb_q <= i_wstrb[sel_idx*STRB_W +: STRB_W];
                    end
                end
            end

            assign o_ram_en[gi]                            = ram_en_q;
            assign o_ram_wren[gi]                          = ram_wren_q;
            assign o_ram_addr[gi*LADDR_W +: LADDR_W]       = ram_addr_q;
            assign o_ram_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = ram_wdata_q;
            assign o_ram_wstrb[gi*STRB_W +: STRB_W]        = ram_wstrb_q;
            assign o_peID[gi*NUM_PE +: NUM_PE]             = peid_q;
        end
    endgenerate

    // Merge per-bank winners; a PE targets one bank so bits never collide
    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            gnt_any = gnt_any | win_oh[b];
        end
        o_gnt = i_rst ? '0 : gnt_any;
    end

    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic [DENY_W-1:0] deny_cnt;
    logic [16:0]       cnt_sum;

    // Count denied requests this cycle and add with saturation at 0xFFFF
    always_comb begin
        deny_cnt = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            deny_cnt = deny_cnt + DENY_W'(i_req[p] & ~o_gnt[p]);
        end
        cnt_sum = {1'b0, cnt_q} + 17'(deny_cnt);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // Conflict counter register, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_conflict_cnt = cnt_q;

endmodule

// File: doc/crossbar_in_arbiter.md
Name: crossbar_in_arbiter

Overview:
- Request-side crossbar stage between PE/config memory ports and the banked instr/data SRAMs.
- Each cycle it arbitrates per-bank among PE requests and grants at most one PE per bank.
- Drives one registered SRAM command per bank.
- Emits the per-bank one-hot PE-select bitmap (o_peID) that the output crossbar delays and uses to steer read data back to the requesting PE.

Parameters:
NUM_PE, 4, number of requesting ports; power of two, ≥2
NUM_BANK, 4, number of SRAM banks; power of two, ≥2; bank = addr[log2(NUM_BANK)-1:0] (word-interleaved)
ADDR_WIDTH, 12, PE word-address width
DATA_WIDTH, 32, data width; multiple of 8

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  NUM_PE  per-PE request valid
i_wren  in  NUM_PE  1 = write, 0 = read
i_addr  in  NUM_PE×ADDR_WIDTH  word address
i_wdata  in  NUM_PE×DATA_WIDTH  write data
i_wstrb  in  NUM_PE×(DATA_WIDTH/8)  byte enables
o_gnt  out  NUM_PE  combinational grant; request accepted this cycle
o_ram_en  out  NUM_BANK  registered bank access enable
o_ram_wren  out  NUM_BANK  registered bank write enable
o_ram_addr  out  NUM_BANK×(ADDR_WIDTH-log2(NUM_BANK))  registered bank-local address = addr >> log2(NUM_BANK)
o_ram_wdata  out  NUM_BANK×DATA_WIDTH  registered write data
o_ram_wstrb  out  NUM_BANK×(DATA_WIDTH/8)  registered byte enables
o_peID  out  NUM_BANK×NUM_PE  registered one-hot reader bitmap; zero for writes and idle banks
o_conflict_cnt  out  16  saturating count of denied requests

Behaviour:
- Single clock i_clk; reset i_rst is synchronous, active-high.
- Reset: all outputs 0; every rr_ptr = 0; o_conflict_cnt = 0.
- While i_rst is high, o_gnt is forced 0 regardless of i_req.
- Handshake:
  - A PE holds i_req/i_wren/i_addr/i_wdata/i_wstrb stable until o_gnt[p]=1 in the same cycle.
  - The transfer occurs on that edge.
  - The PE may present a new request the next cycle.
  - o_gnt is never asserted without i_req.
- Per-bank arbitration, combinational:
  - Candidates for bank b are the PEs with i_req=1 and bank(i_addr)=b.
  - The winner is the first candidate scanning from rr_ptr[b] upward, mod NUM_PE.
  - Each PE targets exactly one bank, so each PE receives at most one grant.
- Pointer update:
  - Bank b grants PE p → rr_ptr[b] <= (p+1) mod NUM_PE.
  - No grant → rr_ptr[b] unchanged.
- Registered command, 1 cycle after grant:
  - Granted bank: o_ram_en[b]=1; wren/addr/wdata/wstrb copied from the winner.
  - Read: o_peID[b] = one-hot(p).
  - Write: o_peID[b] = 0.
  - Non-granted bank: o_ram_en=0, o_ram_wren=0, o_peID=0; addr/wdata/wstrb hold previous values.
- Latency: grant → SRAM command 1 cycle. SRAM read latency and return alignment are handled downstream using o_peID.
- Conflict counter:
  - Each cycle adds popcount(i_req & ~o_gnt).
  - Saturates at 0xFFFF and never wraps.
  - Cleared only by reset.
- Simultaneous read and write to the same bank from different PEs: arbitrated identically; the loser retries.
- Reset mid-operation: a pending un-granted request is dropped from arbiter state. The PE keeps i_req asserted and is arbitrated from rr_ptr=0 after reset deasserts.

Optional Feature:
CROSSBAR_IN_RR_EN
- Defined: round-robin arbitration per bank as above.
- Undefined:
  - Fixed priority; the lowest PE index wins.
  - rr_ptr registers are not instantiated.
  - All other behaviour, including latency, o_peID and the counter, is unchanged.

Test Plan:
All cases use defaults, with CROSSBAR_IN_RR_EN defined unless stated.
1. PE1 read, addr 0x025, alone → o_gnt=0010 same cycle. Next cycle: o_ram_en=0010, o_ram_wren=0, o_ram_addr[1]=0x009, o_peID[1]=0010.
2. PE3 write, addr 0x007, wdata 0xDEADBEEF, wstrb 0xF → o_gnt=1000. Next cycle: o_ram_en[3]=1, o_ram_wren[3]=1, o_ram_addr[3]=0x001, o_ram_wdata[3]=0xDEADBEEF, o_peID[3]=0000.
3. PE0..PE3 read addrs 0x000/0x001/0x002/0x003 → o_gnt=1111 in one cycle. Next cycle o_ram_en=1111, o_peID per bank = 0001/0010/0100/1000; o_conflict_cnt stays 0.
4. All four PEs continuously read bank 2 (addr 0x002) → grants PE0,PE1,PE2,PE3,PE0 on successive cycles; o_conflict_cnt=12 after 4 cycles.
5. During scenario 4, assert i_rst one cycle after PE1 is granted → o_gnt=0000 during reset. Next cycle all outputs are 0. After release, PE0 is granted first.
6. Macro undefined; PE0 and PE2 continuously request bank 1 → PE0 granted every cycle, PE2 never; counter +1 per cycle. Force counter near saturation → holds at 0xFFFF.
